// File: rtl/matrix_res_streamer.sv
// ---------------------------------------------------------------------------
// matrix_res_streamer
//   Unload side of the matrix multiplier. On i_capture the whole parallel
//   result matrix is copied into a local snapshot. The snapshot is then
//   streamed out one element per transfer, row-major, over valid/ready. The
//   multiplier is free to start its next product while the results drain.
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous reset, active-low
//   i_capture    pulse: i_array_res holds a valid result
//   i_array_res  result matrix [HEIGHT_A][WIDTH_B] of 2*BITS-wide elements
//   o_data       current element
//   o_row/o_col  indices of o_data
//   o_valid      o_data/o_row/o_col/o_last are valid
//   i_ready      sink accepts the element this cycle
//   o_last       element is [HEIGHT_A-1][WIDTH_B-1]
//   o_busy       snapshot held, stream in progress
//   o_overrun    sticky: a capture was dropped while busy
// ---------------------------------------------------------------------------
module matrix_res_streamer #(
  parameter int BITS     = 4,
  parameter int HEIGHT_A = 2,
  parameter int WIDTH_B  = 3,
  localparam int DW = 2 * BITS,
  localparam int RW = (HEIGHT_A > 1) ? $clog2(HEIGHT_A) : 1,
  localparam int CW = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_capture,
  input  logic [DW-1:0] i_array_res [HEIGHT_A][WIDTH_B],
  output logic [DW-1:0] o_data,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_overrun
);

  localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT_A - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(WIDTH_B - 1);
  // A 1x1 matrix marks its only element as last from the moment it appears.
  localparam logic LAST_ON_FIRST = (HEIGHT_A == 1) && (WIDTH_B == 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] buf_q [HEIGHT_A][WIDTH_B];
  logic [DW-1:0] buf_d [HEIGHT_A][WIDTH_B];
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;

  logic          xfer;
  logic          start;
  logic [RW-1:0] nrow;
  logic [CW-1:0] ncol;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    row_d     = row_q;
    col_d     = col_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    start     = 1'b0;
    nrow      = row_q;
    ncol      = col_q;

    xfer = valid_q && i_ready;

    // Row-major successor of the current element.
    if (col_q == COL_MAX) begin
      ncol = '0;
      nrow = row_q + RW'(1);
    end else begin
      ncol = col_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_capture) begin
          start = 1'b1;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (last_q) begin
            if (i_capture) begin
              // Final element leaves while a new result arrives: reload with
              // no bubble in between.
              start = 1'b1;
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              last_d  = 1'b0;
              row_d   = '0;
              col_d   = '0;
              data_d  = '0;
            end
          end else begin
            row_d  = nrow;
            col_d  = ncol;
            data_d = buf_q[nrow][ncol];
            last_d = (nrow == ROW_MAX) && (ncol == COL_MAX);
          end
        end
        // Any capture that cannot be taken is dropped and flagged for good.
        if (i_capture && !(xfer && last_q)) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start) begin
      state_d = S_SEND;
      buf_d   = i_array_res;
      row_d   = '0;
      col_d   = '0;
      data_d  = i_array_res[0][0];
      valid_d = 1'b1;
      busy_d  = 1'b1;
      last_d  = LAST_ON_FIRST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      for (int r = 0; r < HEIGHT_A; r++) begin
        for (int c = 0; c < WIDTH_B; c++) begin
          buf_q[r][c] <= '0;
        end
      end
      row_q     <= '0;
      col_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      row_q     <= row_d;
      col_q     <= col_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data    = data_q;
  assign o_row     = row_q;
  assign o_col     = col_q;
  assign o_valid   = valid_q;
  assign o_last    = last_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_matrix_res_streamer.sv
module tb_matrix_res_streamer;

  // Main DUT: 2x3 of 16-bit elements; second DUT: 1x1 of 16-bit elements.
  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        i_capture = 1'b0;
  logic [15:0] res_a [2][3];
  logic [15:0] o_data;
  logic [0:0]  o_row;
  logic [1:0]  o_col;
  logic        o_valid, o_last, o_busy, o_overrun;
  logic        i_ready = 1'b1;

  logic        u_capture = 1'b0;
  logic [15:0] res_b [1][1];
  logic [15:0] u_data;
  logic [0:0]  u_row;
  logic [0:0]  u_col;
  logic        u_valid, u_last, u_busy, u_overrun;
  logic        u_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [0:0]  r;
    logic [1:0]  c;
    logic        l;
  } exp_t;

  exp_t q  [$];
  exp_t q1 [$];

  matrix_res_streamer #(.BITS(8), .HEIGHT_A(2), .WIDTH_B(3)) dut (
    .clk(clk), .reset(reset), .i_capture(i_capture), .i_array_res(res_a),
    .o_data(o_data), .o_row(o_row), .o_col(o_col), .o_valid(o_valid),
    .i_ready(i_ready), .o_last(o_last), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  matrix_res_streamer #(.BITS(8), .HEIGHT_A(1), .WIDTH_B(1)) dut1 (
    .clk(clk), .reset(reset), .i_capture(u_capture), .i_array_res(res_b),
    .o_data(u_data), .o_row(u_row), .o_col(u_col), .o_valid(u_valid),
    .i_ready(u_ready), .o_last(u_last), .o_busy(u_busy), .o_overrun(u_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // ---------------- monitors ----------------
  logic held = 1'b0;
  exp_t held_v;

  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    got = {o_data, o_row, o_col, o_last};
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        if (!o_valid) chk("valid_dropped", 32'(o_valid), 32'd1);
        else          chk("stall_hold", 32'(got), 32'(held_v));
      end
      if (o_valid && i_ready) begin
        held = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_elem", 32'(got), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("elem", 32'(got), 32'(e));
        end
      end else if (o_valid) begin
        held   = 1'b1;
        held_v = got;
      end else begin
        held = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset && u_valid && u_ready) begin
      if (q1.size() == 0) begin
        chk("unexpected_elem_1x1", 32'(u_data), 32'hFFFF_FFFF);
      end else begin
        e = q1.pop_front();
        chk("elem_1x1", 32'({u_data, u_row, 2'b00, u_last}), 32'(e));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input logic [15:0] base);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        res_a[r][c] = base + 16'(r * 3 + c);
  endtask

  task automatic push_mat();
    exp_t e;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        e.d = res_a[r][c];
        e.r = 1'(r);
        e.c = 2'(c);
        e.l = (r == 1) && (c == 2);
        q.push_back(e);
      end
  endtask

  task automatic capture();
    i_capture = 1'b1;
    step();
    i_capture = 1'b0;
  endtask

  task automatic drain(input logic [3:0] patt, input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      if (q.size() == 0 && !o_valid) break;
      i_ready = patt[k % 4];
      step();
    end
    i_ready = 1'b1;
    chk({nm, "_drained"}, 32'(q.size() == 0 && !o_valid), 32'd1);
  endtask

  initial begin
    exp_t e;
    load_seq(16'd0);
    res_b[0][0] = 16'd0;
    #12;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_outs", 32'({o_data, o_row, o_col, o_last, o_busy, o_overrun}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // 1: plain stream, ready always high, no bubbles
    load_seq(16'd1);
    push_mat();
    capture();
    for (int k = 0; k < 6; k++) begin
      chk("t1_no_bubble", 32'(o_valid && o_busy), 32'd1);
      step();
    end
    chk("t1_end_valid", 32'(o_valid), 32'd0);
    chk("t1_end_busy_idx", 32'({o_busy, o_row, o_col}), 32'd0);
    chk("t1_overrun", 32'(o_overrun), 32'd0);

    // 2: back-pressure 1,0,0,1
    load_seq(16'd1);
    push_mat();
    capture();
    drain(4'b1001, "t2");

    // 4: back-to-back capture on the final-transfer cycle
    load_seq(16'd1);
    push_mat();
    capture();
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid", 32'(o_valid), 32'd1);
      step();
    end
    chk("t4_last_shown", 32'(o_last), 32'd1);
    load_seq(16'd9);
    push_mat();
    capture();
    chk("t4_no_bubble", 32'({o_valid, o_busy, o_data}), 32'({2'b11, 16'd9}));
    chk("t4_no_overrun", 32'(o_overrun), 32'd0);
    drain(4'b1111, "t4");
    chk("t4_overrun_after", 32'(o_overrun), 32'd0);

    // 3: recapture mid-stream is dropped and flagged
    load_seq(16'd1);
    push_mat();
    capture();
    step();
    step();
    load_seq(16'd9);
    capture();
    chk("t3_overrun_set", 32'(o_overrun), 32'd1);
    drain(4'b1111, "t3");
    chk("t3_overrun_sticky", 32'(o_overrun), 32'd1);
    step();
    chk("t3_overrun_idle", 32'({o_overrun, o_valid}), 32'b10);

    // 5: reset mid-stream
    load_seq(16'd1);
    push_mat();
    capture();
    step();
    step();
    reset = 1'b0;
    #1;
    q.delete();
    chk("t5_rst_outs", 32'({o_data, o_row, o_col, o_valid, o_last, o_busy, o_overrun}), 32'd0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("t5_stay_idle", 32'({o_valid, o_busy}), 32'd0);

    // 6: full-width values and 1x1 config
    res_a[0][0] = 16'hFE01; res_a[0][1] = 16'hFFFF; res_a[0][2] = 16'h0000;
    res_a[1][0] = 16'h8000; res_a[1][1] = 16'h7FFF; res_a[1][2] = 16'hFE01;
    push_mat();
    capture();
    load_seq(16'h1234);  // later input changes must not leak into the stream
    drain(4'b1111, "t6");

    res_b[0][0] = 16'hFE01;
    e.d = 16'hFE01; e.r = 1'b0; e.c = 2'd0; e.l = 1'b1;
    q1.push_back(e);
    u_capture = 1'b1;
    step();
    u_capture = 1'b0;
    res_b[0][0] = 16'h0000;
    chk("t6_1x1_first", 32'({u_valid, u_last, u_busy}), 32'b111);
    step();
    chk("t6_1x1_done", 32'({u_valid, u_busy}), 32'd0);
    chk("t6_1x1_queue", 32'(q1.size()), 32'd0);
    chk("end_queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
